// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with a registered output slot.
// Channel choice is round-robin (mode=0) or forced through sel (mode=1).
module rr_stream_mux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  last_q, last_d;

  logic             load_s;
  logic [N-1:0]     grant_s;
  logic [SELW-1:0]  grant_idx_s;
  logic             grant_any_s;
  logic             xfer_s;

  // The output slot can take a new item if it is empty or draining this cycle.
  assign load_s = ~out_valid_q | out_ready;

  // Grant selection: forced channel, or the first valid channel after last.
  always_comb begin
    grant_s     = {N{1'b0}};
    grant_idx_s = {SELW{1'b0}};
    grant_any_s = 1'b0;
    if (mode) begin
      if (int'(sel) < N) begin
        grant_s[sel] = in_valid[sel];
        grant_idx_s  = sel;
        grant_any_s  = in_valid[sel];
      end else begin
        grant_any_s = 1'b0;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (!grant_any_s && in_valid[(int'(last_q) + k) % N]) begin
          grant_any_s = 1'b1;
          grant_idx_s = SELW'((int'(last_q) + k) % N);
          grant_s[(int'(last_q) + k) % N] = 1'b1;
        end else begin
          grant_any_s = grant_any_s;
        end
      end
    end
  end

  // Ready is withheld while the slot is busy and during reset.
  always_comb begin
    if (load_s && !reset) begin
      in_ready = grant_s;
    end else begin
      in_ready = {N{1'b0}};
    end
  end

  assign xfer_s = load_s & grant_any_s & ~reset;

  // Next state of the output slot and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (xfer_s) begin
      out_data_d  = in_data[int'(grant_idx_s)*WIDTH +: WIDTH];
      out_chan_d  = grant_idx_s;
      out_valid_d = 1'b1;
      last_d      = grant_idx_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset; last starts at N-1 so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= {WIDTH{1'b0}};
      out_chan_q  <= {SELW{1'b0}};
      out_valid_q <= 1'b0;
      last_q      <= SELW'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule
